// File: rtl/adder_tree_acc_if.sv
// rtl/adder_tree_acc_if.sv - beat input / result output handshake bundle for adder_tree_acc
interface adder_tree_acc_if #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int CH_NUM      = 4
);
  localparam int OUT_WIDTH = WIDTH + $clog2(KERNEL_SIZE) + $clog2(CH_NUM);

  logic [KERNEL_SIZE-1:0][WIDTH-1:0] din;
  logic                              in_valid;
  logic                              in_ready;
  logic                              flush;
  logic [OUT_WIDTH-1:0]              dout;
  logic                              out_valid;
  logic                              out_ready;

  modport master (
    output din, in_valid, flush, out_ready,
    input  in_ready, dout, out_valid
  );

  modport slave (
    input  din, in_valid, flush, out_ready,
    output in_ready, dout, out_valid
  );
endinterface

// File: rtl/adder_tree_acc.sv
// rtl/adder_tree_acc.sv - pipelined signed adder tree with per-channel accumulation
module adder_tree_acc #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int CH_NUM      = 4
) (
  input  logic           clk,
  input  logic           rst,
  adder_tree_acc_if.slave bus
);
  localparam int LVL       = $clog2(KERNEL_SIZE);
  localparam int OUT_WIDTH = WIDTH + LVL + $clog2(CH_NUM);
  localparam int CNT_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  function automatic int nodes(input int k);
    int n;
    n = KERNEL_SIZE;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic                 en;
  logic                 accept;
  logic                 out_valid_r;
  logic [OUT_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 res_v;
  logic [OUT_WIDTH-1:0] res_d;

  // The whole pipeline freezes only while a finished result is waiting to be taken.
  assign en           = !out_valid_r || bus.out_ready;
  assign bus.in_ready = rst && en && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k <= LVL; k++) begin : g_lvl
    localparam int NO = nodes(k);
    logic                 v;
    logic [OUT_WIDTH-1:0] d [NO];

    if (k == 0) begin : g_in
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v <= 1'b0;
          for (int j = 0; j < NO; j++) d[j] <= '0;
        end else if (bus.flush) begin
          v <= 1'b0;
        end else if (en) begin
          v <= accept;
          if (accept) begin
            for (int j = 0; j < NO; j++) d[j] <= OUT_WIDTH'($signed(bus.din[j]));
          end
        end
      end
    end else begin : g_add
      localparam int NP = nodes(k - 1);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v <= 1'b0;
          for (int j = 0; j < NO; j++) d[j] <= '0;
        end else if (bus.flush) begin
          v <= 1'b0;
        end else if (en) begin
          v <= g_lvl[k-1].v;
          for (int j = 0; j < NP / 2; j++) begin
            d[j] <= g_lvl[k-1].d[2*j] + g_lvl[k-1].d[2*j+1];
          end
          // Leftover odd operand rides through this level untouched.
          if (NP % 2 == 1) d[NO-1] <= g_lvl[k-1].d[NP-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_v <= 1'b0;
      res_d <= '0;
    end else if (bus.flush) begin
      res_v <= 1'b0;
    end else if (en) begin
      res_v <= g_lvl[LVL].v;
      res_d <= g_lvl[LVL].d[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      cnt         <= '0;
      out_valid_r <= 1'b0;
    end else if (en) begin
      out_valid_r <= 1'b0;
      if (res_v) begin
        acc <= (cnt == '0) ? res_d : acc + res_d;
        if (cnt == CNT_W'(CH_NUM - 1)) begin
          out_valid_r <= 1'b1;
          cnt         <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dout      = out_valid_r ? acc : '0;
endmodule

// File: tb/tb_adder_tree_acc.sv
// tb/tb_adder_tree_acc.sv - scoreboard bench for adder_tree_acc (9x4 and 1x1 configurations)
module tb_adder_tree_acc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_tree_acc_if #(.WIDTH(8), .KERNEL_SIZE(9), .CH_NUM(4)) bi ();
  adder_tree_acc_if #(.WIDTH(8), .KERNEL_SIZE(1), .CH_NUM(1)) si ();

  adder_tree_acc #(.WIDTH(8), .KERNEL_SIZE(9), .CH_NUM(4)) u_big (.clk(clk), .rst(rst), .bus(bi));
  adder_tree_acc #(.WIDTH(8), .KERNEL_SIZE(1), .CH_NUM(1)) u_small (.clk(clk), .rst(rst), .bus(si));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int big_cnt = 0;
  int big_sum = 0;
  int lat;
  int acc_c;
  int sm_first;
  int sm_tmp;
  int sm_lat;
  int sm_run;
  int seen;
  logic signed [13:0] big_q[$];
  logic signed [7:0]  sm_q[$];
  logic signed [13:0] big_exp;
  logic signed [7:0]  sm_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: pop and compare on every consumed result.
  always @(negedge clk) begin
    if (rst && bi.out_valid && bi.out_ready) begin
      n_cmp++;
      if (big_q.size() == 0) begin
        n_err++;
        $display("FAIL big_sb: unexpected result %0d, required none", $signed(bi.dout));
      end else begin
        big_exp = big_q.pop_front();
        if ($signed(bi.dout) !== big_exp) begin
          n_err++;
          $display("FAIL big_sb: dout %0d, required %0d", $signed(bi.dout), big_exp);
        end
      end
    end
    if (rst && si.out_valid && si.out_ready) begin
      n_cmp++;
      if (sm_q.size() == 0) begin
        n_err++;
        $display("FAIL small_sb: unexpected result %0d, required none", $signed(si.dout));
      end else begin
        sm_exp = sm_q.pop_front();
        if ($signed(si.dout) !== sm_exp) begin
          n_err++;
          $display("FAIL small_sb: dout %0d, required %0d", $signed(si.dout), sm_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [8:0][7:0] all_lanes(input int v);
    logic [8:0][7:0] r;
    for (int i = 0; i < 9; i++) r[i] = 8'(v);
    return r;
  endfunction

  task automatic send_big(input logic [8:0][7:0] lanes);
    int s;
    bit done;
    done = 1'b0;
    bi.din = lanes;
    bi.in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bi.in_ready) begin
        s = 0;
        for (int i = 0; i < 9; i++) s += int'($signed(lanes[i]));
        big_sum = (big_cnt == 0) ? s : big_sum + s;
        if (big_cnt == 3) begin
          big_q.push_back(14'(big_sum));
          big_cnt = 0;
        end else begin
          big_cnt++;
        end
        @(posedge clk); #1;
        acc_c = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    bi.in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL big_accept: beat accepted %0b, required 1", done);
    end
  endtask

  task automatic send_small(input int v, output int when);
    bit done;
    done = 1'b0;
    when = -1;
    si.din[0] = 8'(v);
    si.in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (si.in_ready) begin
        sm_q.push_back(8'(v));
        @(posedge clk); #1;
        when = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    si.in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL small_accept: beat accepted %0b, required 1", done);
    end
  endtask

  task automatic wait_big(output int l);
    l = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bi.out_valid) begin
        l = cyc - acc_c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bi.din = '0; bi.in_valid = 1'b0; bi.flush = 1'b0; bi.out_ready = 1'b1;
    si.din = '0; si.in_valid = 1'b0; si.flush = 1'b0; si.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bi.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b, want 0", bi.out_valid); end
    n_cmp++; if (bi.dout !== 14'd0) begin n_err++; $display("FAIL reset_dout: got %0d, want 0", bi.dout); end
    n_cmp++; if (bi.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b, want 0", bi.in_ready); end
    n_cmp++; if (si.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_small_valid: got %0b, want 0", si.out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bi.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %0b, want 1", bi.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_ones();
    for (int b = 0; b < 4; b++) send_big(all_lanes(1));
    wait_big(lat);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL ones_latency: got %0d, want 6", lat); end
    n_cmp++; if (bi.dout !== 14'd36) begin n_err++; $display("FAIL ones_dout: got %0d, want 36", $signed(bi.dout)); end
    @(negedge clk);
    n_cmp++; if (bi.out_valid !== 1'b0) begin n_err++; $display("FAIL ones_pulse: out_valid %0b, want 0", bi.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_extremes();
    logic [8:0][7:0] ramp;
    for (int b = 0; b < 4; b++) send_big(all_lanes(-128));
    wait_big(lat);
    n_cmp++; if (bi.dout !== 14'h2E00) begin n_err++; $display("FAIL min_dout: got %0h, want 2e00", bi.dout); end
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) ramp[i] = 8'(i + 1);
    for (int b = 0; b < 4; b++) send_big(ramp);
    wait_big(lat);
    n_cmp++; if (bi.dout !== 14'd180) begin n_err++; $display("FAIL ramp_dout: got %0d, want 180", $signed(bi.dout)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bi.out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_big(all_lanes(3));
    for (int b = 1; b <= 4; b++) send_big(all_lanes(b));
    wait_big(lat);
    n_cmp++; if (lat < 0) begin n_err++; $display("FAIL bp_first_timeout: latency %0d, want >=0", lat); end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      n_cmp++; if (bi.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b, want 0", bi.in_ready); end
      n_cmp++; if (bi.dout !== 14'd108) begin n_err++; $display("FAIL bp_hold: got %0d, want 108", $signed(bi.dout)); end
    end
    @(posedge clk); #1;
    bi.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wait_big(lat);
    n_cmp++; if (bi.dout !== 14'd90) begin n_err++; $display("FAIL bp_second: got %0d, want 90", $signed(bi.dout)); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    send_big(all_lanes(7));
    send_big(all_lanes(7));
    bi.flush = 1'b1;
    bi.din = all_lanes(9);
    bi.in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bi.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b, want 0", bi.in_ready); end
    @(posedge clk); #1;
    bi.flush = 1'b0;
    bi.in_valid = 1'b0;
    big_cnt = 0;
    for (int b = 0; b < 4; b++) send_big(all_lanes(2));
    wait_big(lat);
    n_cmp++; if (bi.dout !== 14'd72) begin n_err++; $display("FAIL flush_dout: got %0d, want 72", $signed(bi.dout)); end
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL flush_latency: got %0d, want 6", lat); end
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bi.out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_extra: got %0d results, want 0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bi.out_ready = 1'b0;
    for (int b = 0; b < 6; b++) send_big(all_lanes(5));
    wait_big(lat);
    n_cmp++; if (bi.dout !== 14'd180) begin n_err++; $display("FAIL rmid_pre: got %0d, want 180", $signed(bi.dout)); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bi.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %0b, want 0", bi.out_valid); end
    n_cmp++; if (bi.dout !== 14'd0) begin n_err++; $display("FAIL rmid_dout: got %0d, want 0", $signed(bi.dout)); end
    n_cmp++; if (bi.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready: got %0b, want 0", bi.in_ready); end
    big_q.delete();
    big_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    bi.out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (bi.out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rmid_spurious: got %0d results, want 0", seen); end
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) send_big(all_lanes(1));
    wait_big(lat);
    n_cmp++; if (bi.dout !== 14'd36) begin n_err++; $display("FAIL rmid_after: got %0d, want 36", $signed(bi.dout)); end
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    sm_first = -1;
    fork
      begin
        send_small(-5, sm_first);
        send_small(3, sm_tmp);
        send_small(-128, sm_tmp);
        send_small(127, sm_tmp);
      end
      begin
        sm_lat = -1;
        sm_run = 0;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (si.out_valid) begin
            sm_lat = cyc - sm_first;
            break;
          end
        end
        if (sm_lat >= 0) begin
          sm_run = 1;
          for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (si.out_valid) sm_run++;
            else break;
          end
        end
      end
    join
    n_cmp++; if (sm_lat !== 2) begin n_err++; $display("FAIL small_latency: got %0d, want 2", sm_lat); end
    n_cmp++; if (sm_run !== 4) begin n_err++; $display("FAIL small_rate: got %0d consecutive, want 4", sm_run); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ones();
    test_extremes();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_small();
    repeat (5) @(negedge clk);
    n_cmp++; if (big_q.size() !== 0) begin n_err++; $display("FAIL big_drain: %0d pending, want 0", big_q.size()); end
    n_cmp++; if (sm_q.size() !== 0) begin n_err++; $display("FAIL small_drain: %0d pending, want 0", sm_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
